pixel_readout_buffer: RTL and testbench

- Downstream consumer of the pixel array/state-machine top. Captures the 16-bit DATA_OUT word presented during each READ1 and READ2 phase.
- Each word carries two 8-bit pixels, so one frame is 2 words = 4 pixels.
- Words are queued in a small FIFO and unpacked into an 8-bit pixel stream with valid/ready handshake and start/end-of-frame tags, decoupling the sensor timing from the downstream consumer.

---
 rtl/pixel_readout_buffer_if.sv | 21 ++
 rtl/pixel_readout_buffer.sv | 158 +++++++++++++++
 tb/tb_pixel_readout_buffer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_readout_buffer_if.sv
// rtl/pixel_readout_buffer_if.sv - pixel stream handshake bundle
// Purpose: carries the unpacked pixel stream with valid/ready handshake and frame tags.
// Signals:
//   pix_data  - current pixel (low byte of the head word first, then high byte)
//   pix_valid - pix_data/pix_sof/pix_eof are valid
//   pix_ready - consumer accepts the pixel when pix_valid && pix_ready at a rising edge
//   pix_sof   - first pixel of a frame
//   pix_eof   - last pixel of a frame
// Modports: master (the buffer drives the stream), slave (the consumer).
interface pixel_readout_buffer_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_sof;
  logic             pix_eof;

  modport master (output pix_data, pix_valid, pix_sof, pix_eof, input pix_ready);
  modport slave  (input pix_data, pix_valid, pix_sof, pix_eof, output pix_ready);
endinterface

// File: rtl/pixel_readout_buffer.sv
// rtl/pixel_readout_buffer.sv - captures READ1/READ2 words, buffers them, streams pixels
// Purpose: latches the pixel array word on each read phase, queues tagged words in a
//   small FIFO and unpacks each word into two pixels with start/end-of-frame tags.
// Ports:
//   clk, rst     - rising-edge clock, asynchronous active-high reset
//   read1, read2 - read phase strobes; the word is pushed on the strobe's falling edge
//   erase        - rising edge starts a new frame and clears the sticky flags
//   data_in      - pixel array output word
//   pix          - pixel stream (master modport)
//   overflow     - sticky: a word was dropped because the FIFO was full
//   proto_err    - sticky: both strobes high together, or out-of-order read phases
//   level        - number of words in the FIFO (a half-consumed word still counts)
//   frame_cnt, drop_cnt - only present when PIXEL_READOUT_STATS_EN is defined
// Optional feature macro: PIXEL_READOUT_STATS_EN
module pixel_readout_buffer #(
  parameter int DATA_W     = 16,
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        read1,
  input  logic                        read2,
  input  logic                        erase,
  input  logic [DATA_W-1:0]           data_in,
  pixel_readout_buffer_if.master      pix,
  output logic                        overflow,
  output logic                        proto_err,
  output logic [$clog2(FIFO_DEPTH):0] level
`ifdef PIXEL_READOUT_STATS_EN
  ,
  output logic [15:0]                 frame_cnt,
  output logic [7:0]                  drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic {IDLE, GOT_R1} frame_state_e;

  frame_state_e      state_q, state_d;
  logic              seq_err;
  logic              read1_d, read2_d, erase_d;
  logic              poison;
  logic [DATA_W-1:0] hold;
  logic              hold_tag;
  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              byte_sel;
  logic [DATA_W:0]   head;
  logic              push_req, push_ok, drop, pop, accept;
  logic              empty, full, erase_rise, both;

  assign both       = read1 & read2;
  assign erase_rise = erase & ~erase_d;
  // A strobe that overlapped its sibling poisons the phase until both strobes are low,
  // so the falling edges that follow a collision never push a word.
  assign push_req   = ((read1_d & ~read1) | (read2_d & ~read2)) & ~poison;

  assign level  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head   = mem[rd_ptr[AW-1:0]];
  assign accept = pix.pix_valid & pix.pix_ready;
  assign pop    = accept & byte_sel;
  // A simultaneous pop frees the slot, so a full FIFO still takes the word.
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  // Outputs are gated by empty so the never-reset storage cannot leak onto the bus.
  assign pix.pix_valid = ~empty;
  assign pix.pix_data  = empty ? '0 : (byte_sel ? head[2*PIX_W-1:PIX_W] : head[PIX_W-1:0]);
  assign pix.pix_sof   = ~empty & ~byte_sel & ~head[DATA_W];
  assign pix.pix_eof   = ~empty & byte_sel & head[DATA_W];

  always_comb begin
    state_d = state_q;
    seq_err = 1'b0;
    if (push_req) begin
      case (state_q)
        IDLE: begin
          if (!hold_tag) state_d = GOT_R1;
          else           seq_err = 1'b1;
        end
        GOT_R1: begin
          if (hold_tag) state_d = IDLE;
          else          seq_err = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    if (erase_rise) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read1_d   <= 1'b0;
      read2_d   <= 1'b0;
      erase_d   <= 1'b0;
      poison    <= 1'b0;
      hold      <= '0;
      hold_tag  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      byte_sel  <= 1'b0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      read1_d <= read1;
      read2_d <= read2;
      erase_d <= erase;

      if (both)                poison <= 1'b1;
      else if (!read1 && !read2) poison <= 1'b0;

      if (read1 ^ read2) begin
        hold     <= data_in;
        hold_tag <= read2;
      end

      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (accept)  byte_sel <= ~byte_sel;

      // Clears come first so an error on the erase edge itself is still recorded.
      if (erase_rise) begin
        overflow  <= 1'b0;
        proto_err <= 1'b0;
      end
      if (drop)           overflow  <= 1'b1;
      if (both || seq_err) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {hold_tag, hold};
  end

`ifdef PIXEL_READOUT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (accept && pix.pix_eof)   frame_cnt <= frame_cnt + 16'd1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// tb/tb_pixel_readout_buffer.sv - bench for pixel_readout_buffer
module tb_pixel_readout_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read1 = 1'b0;
  logic        read2 = 1'b0;
  logic        erase = 1'b0;
  logic [15:0] data_in = '0;
  logic        overflow, proto_err;
  logic [2:0]  level;
`ifdef PIXEL_READOUT_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int eof_model = 0;
  logic [9:0] exp_q[$];

  pixel_readout_buffer_if #(.PIX_W(8)) pix_if ();

  pixel_readout_buffer #(.DATA_W(16), .PIX_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .read1(read1), .read2(read2), .erase(erase),
    .data_in(data_in), .pix(pix_if.master), .overflow(overflow),
    .proto_err(proto_err), .level(level)
`ifdef PIXEL_READOUT_STATS_EN
    , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic is_r2, input logic [15:0] word);
    exp_q.push_back({~is_r2, 1'b0, word[7:0]});
    exp_q.push_back({1'b0, is_r2, word[15:8]});
  endtask

  task automatic strobe(input logic is_r2, input logic [15:0] word, input bit expect_it);
    data_in = word;
    read1 = ~is_r2;
    read2 = is_r2;
    tick();
    read1 = 1'b0;
    read2 = 1'b0;
    tick();
    if (expect_it) push_exp(is_r2, word);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    pix_if.pix_ready = 1'b1;
    while ((exp_q.size() != 0 || level != 3'd0) && n < 64) begin
      tick();
      n++;
    end
    check(tag, 32'((exp_q.size() == 0) && (level == 3'd0)), 32'd1);
  endtask

  // Scoreboard consumer: every accepted pixel must match the next expected one.
  always @(negedge clk) begin
    if (!rst && pix_if.pix_valid && pix_if.pix_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_pixel observed=%0h expected=none",
               {pix_if.pix_sof, pix_if.pix_eof, pix_if.pix_data});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (e[8]) eof_model++;
        assert ({pix_if.pix_sof, pix_if.pix_eof, pix_if.pix_data} === e) else begin
          errors++;
          $error("FAIL pixel observed=%0h expected=%0h",
                 {pix_if.pix_sof, pix_if.pix_eof, pix_if.pix_data}, e);
        end
      end
    end
  end

  initial begin
    pix_if.pix_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(pix_if.pix_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_data", 32'(pix_if.pix_data), 32'd0);
    check("rst_flags", 32'({overflow, proto_err, pix_if.pix_sof, pix_if.pix_eof}), 32'd0);
    rst = 1'b0;
    tick();

    // Basic frame with consumer always ready.
    pix_if.pix_ready = 1'b1;
    data_in = 16'hB2A1;
    read1 = 1'b1;
    tick();
    check("t1_valid_capture", 32'(pix_if.pix_valid), 32'd0);
    read1 = 1'b0;
    tick();
    push_exp(1'b0, 16'hB2A1);
    check("t1_valid_push", 32'(pix_if.pix_valid), 32'd1);
    check("t1_first_pixel", 32'({pix_if.pix_sof, pix_if.pix_data}), 32'h1A1);
    check("t1_level", 32'(level), 32'd1);
    strobe(1'b1, 16'hD4C3, 1'b1);
    drain("t1_drain");
    check("t1_proto", 32'(proto_err), 32'd0);

    // Overflow with stalled consumer, then erase and drain.
    pix_if.pix_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(i[0], 16'h1110 + 16'(i * 16'h0202), 1'b1);
    check("t2_level_full", 32'(level), 32'd4);
    check("t2_no_ovf", 32'(overflow), 32'd0);
    strobe(1'b0, 16'hEEDD, 1'b0);
    check("t2_level_after_drop", 32'(level), 32'd4);
    check("t2_ovf", 32'(overflow), 32'd1);
    erase = 1'b1;
    tick();
    erase = 1'b0;
    tick();
    check("t2_ovf_cleared", 32'(overflow), 32'd0);
    drain("t2_drain");

    // Backpressure inside a word: stall on the high byte.
    pix_if.pix_ready = 1'b0;
    strobe(1'b0, 16'h5A3C, 1'b1);
    strobe(1'b1, 16'h7E6D, 1'b1);
    pix_if.pix_ready = 1'b1;
    tick();
    pix_if.pix_ready = 1'b0;
    check("t3_high_byte", 32'(pix_if.pix_data), 32'h5A);
    tick();
    check("t3_hold1", 32'({pix_if.pix_valid, pix_if.pix_data}), 32'h15A);
    tick();
    check("t3_hold2", 32'({pix_if.pix_valid, pix_if.pix_data}), 32'h15A);
    check("t3_level_half", 32'(level), 32'd2);
    pix_if.pix_ready = 1'b1;
    tick();
    pix_if.pix_ready = 1'b0;
    check("t3_next_word", 32'(pix_if.pix_data), 32'h6D);
    check("t3_level_pop", 32'(level), 32'd1);
    drain("t3_drain");

    // Both strobes together, then a lone READ2 from IDLE.
    pix_if.pix_ready = 1'b0;
    data_in = 16'h0F0F;
    read1 = 1'b1;
    read2 = 1'b1;
    tick();
    tick();
    read1 = 1'b0;
    read2 = 1'b0;
    tick();
    tick();
    check("t4_both_err", 32'(proto_err), 32'd1);
    check("t4_both_level", 32'(level), 32'd0);
    erase = 1'b1;
    tick();
    erase = 1'b0;
    tick();
    check("t4_err_cleared", 32'(proto_err), 32'd0);
    strobe(1'b1, 16'h9988, 1'b1);
    check("t4_r2_err", 32'(proto_err), 32'd1);
    check("t4_r2_level", 32'(level), 32'd1);
    check("t4_no_sof", 32'(pix_if.pix_sof), 32'd0);
    drain("t4_drain");
    erase = 1'b1;
    tick();
    erase = 1'b0;
    tick();

    // Full FIFO: push and pop on the same edge.
    pix_if.pix_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(i[0], 16'h3130 + 16'(i * 16'h0202), 1'b1);
    check("t5_level_full", 32'(level), 32'd4);
    pix_if.pix_ready = 1'b1;
    tick();
    pix_if.pix_ready = 1'b0;
    data_in = 16'hF1E0;
    read1 = 1'b1;
    tick();
    read1 = 1'b0;
    pix_if.pix_ready = 1'b1;
    tick();
    push_exp(1'b0, 16'hF1E0);
    pix_if.pix_ready = 1'b0;
    check("t5_level_same", 32'(level), 32'd4);
    check("t5_no_ovf", 32'(overflow), 32'd0);
    drain("t5_drain");

    // Reset with a half-consumed word pending.
    pix_if.pix_ready = 1'b0;
    strobe(1'b0, 16'h4433, 1'b1);
    strobe(1'b1, 16'h6655, 1'b1);
    check("t6_level", 32'(level), 32'd2);
    pix_if.pix_ready = 1'b1;
    tick();
    pix_if.pix_ready = 1'b0;
    check("t6_high_pending", 32'(pix_if.pix_data), 32'h44);
`ifdef PIXEL_READOUT_STATS_EN
    check("t6_frame_cnt", 32'(frame_cnt), 32'(eof_model));
    check("t6_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("t6_rst_valid", 32'(pix_if.pix_valid), 32'd0);
    check("t6_rst_level", 32'(level), 32'd0);
    check("t6_rst_outs", 32'({pix_if.pix_sof, pix_if.pix_eof, pix_if.pix_data}), 32'd0);
`ifdef PIXEL_READOUT_STATS_EN
    check("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    check("t6_post_rst_valid", 32'(pix_if.pix_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
